// File: rtl/csr_access_arbiter_if.sv
// Bundle of the core/debug request ports and the shared CSR bus.
// slave is the arbiter's view; master is the requester/bus-model view.
interface csr_access_arbiter_if;
   logic        coreRequest;
   logic [1:0]  coreOp;
   logic [11:0] coreAddress;
   logic [31:0] coreWriteData;
   logic        coreAck;
   logic [31:0] coreReadData;
   logic        coreError;

   logic        debugRequest;
   logic [1:0]  debugOp;
   logic [11:0] debugAddress;
   logic [31:0] debugWriteData;
   logic        debugAck;
   logic [31:0] debugReadData;
   logic        debugError;

   logic        csrReadEnable;
   logic        csrWriteEnable;
   logic [11:0] csrAddress;
   logic [31:0] csrWriteData;
   logic [31:0] csrReadData;
   logic        busy;

   modport slave (
      input  coreRequest, coreOp, coreAddress, coreWriteData,
      output coreAck, coreReadData, coreError,
      input  debugRequest, debugOp, debugAddress, debugWriteData,
      output debugAck, debugReadData, debugError,
      output csrReadEnable, csrWriteEnable, csrAddress, csrWriteData,
      input  csrReadData,
      output busy
   );

   modport master (
      output coreRequest, coreOp, coreAddress, coreWriteData,
      input  coreAck, coreReadData, coreError,
      output debugRequest, debugOp, debugAddress, debugWriteData,
      input  debugAck, debugReadData, debugError,
      input  csrReadEnable, csrWriteEnable, csrAddress, csrWriteData,
      output csrReadData,
      input  busy
   );
endinterface

// File: rtl/csr_access_arbiter.sv
// Round-robin core/debug arbiter doing read -> modify -> optional write on the CSR bus.
// Ack 3 cycles after grant (4 with a write); requests are held until Ack, sampled only in IDLE.
module csr_access_arbiter (
   input  logic clk,
   input  logic rst,
   csr_access_arbiter_if.slave csr_if
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

   localparam logic       PORT_CORE  = 1'b0;
   localparam logic       PORT_DEBUG = 1'b1;
   localparam logic [1:0] OP_RW      = 2'b01;
   localparam logic [1:0] OP_RS      = 2'b10;
   localparam logic [1:0] OP_RC      = 2'b11;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_grant;
   logic        r_last_grant;
   logic [1:0]  r_op;
   logic [11:0] r_addr;
   logic [31:0] r_operand;
   logic [31:0] r_old_value;
   logic [31:0] r_new_value;
   logic        r_illegal;

   logic        w_tie;
   logic        w_grant_vld;
   logic        w_grant_sel;
   logic [31:0] w_new_value;
   logic        w_write_needed;
   logic        w_illegal;

   always_comb begin
      w_tie          = csr_if.coreRequest & csr_if.debugRequest;
      w_grant_vld    = csr_if.coreRequest | csr_if.debugRequest;
      w_grant_sel    = w_tie ? ~r_last_grant : csr_if.debugRequest;
      // csrReadData is only meaningful here while in WAIT
      case (r_op)
         OP_RW:   w_new_value = r_operand;
         OP_RS:   w_new_value = csr_if.csrReadData | r_operand;
         OP_RC:   w_new_value = csr_if.csrReadData & ~r_operand;
         default: w_new_value = csr_if.csrReadData;
      endcase
      w_write_needed = (r_op == OP_RW) || (((r_op == OP_RS) || (r_op == OP_RC)) && (r_operand != 32'd0));
      w_illegal      = w_write_needed && (r_addr[11:10] == 2'b11);

      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_grant_vld) w_next_state = READ;
         READ:    w_next_state = WAIT;
         WAIT:    w_next_state = (w_write_needed && !w_illegal) ? WRITE : RESP;
         WRITE:   w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_grant      <= PORT_CORE;
         r_last_grant <= PORT_DEBUG;
         r_op         <= 2'b00;
         r_addr       <= 12'd0;
         r_operand    <= 32'd0;
         r_old_value  <= 32'd0;
         r_new_value  <= 32'd0;
         r_illegal    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == IDLE) && w_grant_vld) begin
            r_grant   <= w_grant_sel;
            r_op      <= w_grant_sel ? csr_if.debugOp        : csr_if.coreOp;
            r_addr    <= w_grant_sel ? csr_if.debugAddress   : csr_if.coreAddress;
            r_operand <= w_grant_sel ? csr_if.debugWriteData : csr_if.coreWriteData;
            // Round-robin pointer only moves when a tie is actually resolved
            if (w_tie) r_last_grant <= w_grant_sel;
         end
         if (r_state == WAIT) begin
            r_old_value <= csr_if.csrReadData;
            r_new_value <= w_new_value;
            r_illegal   <= w_illegal;
         end
      end
   end

   // Decoded from r_state so an async reset drops every strobe at once
   always_comb begin
      csr_if.csrReadEnable  = (r_state == READ);
      csr_if.csrWriteEnable = (r_state == WRITE);
      csr_if.csrAddress     = ((r_state == READ) || (r_state == WRITE)) ? r_addr : 12'd0;
      csr_if.csrWriteData   = (r_state == WRITE) ? r_new_value : 32'd0;
      csr_if.busy           = (r_state != IDLE);
      csr_if.coreAck        = (r_state == RESP) && (r_grant == PORT_CORE);
      csr_if.debugAck       = (r_state == RESP) && (r_grant == PORT_DEBUG);
      csr_if.coreReadData   = csr_if.coreAck  ? r_old_value : 32'd0;
      csr_if.coreError      = csr_if.coreAck  ? r_illegal   : 1'b0;
      csr_if.debugReadData  = csr_if.debugAck ? r_old_value : 32'd0;
      csr_if.debugError     = csr_if.debugAck ? r_illegal   : 1'b0;
   end
endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench: a reference CSR memory predicts each access when issued; a monitor checks acks and bus strobes.
module tb_csr_access_arbiter;
   logic clk = 1'b0;
   logic rst;
   csr_access_arbiter_if bus ();

   csr_access_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .csr_if (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_exp_t;

   ack_exp_t    ack_q_core[$];
   ack_exp_t    ack_q_dbg[$];
   logic [11:0] rd_q[$];
   wr_exp_t     wr_q[$];
   logic [31:0] bus_mem [4096];
   logic [31:0] ref_mem [4096];
   bit          tb_last = 1'b1;   // previous tie winner; debug after reset

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // CSR bus model: reads answer on the cycle after the strobe, otherwise the data lines carry junk
   logic        s_re, s_we;
   logic [11:0] s_addr;
   logic [31:0] s_wd;
   always @(posedge clk) begin
      s_re   = bus.csrReadEnable;
      s_we   = bus.csrWriteEnable;
      s_addr = bus.csrAddress;
      s_wd   = bus.csrWriteData;
      #1;
      if (s_we) bus_mem[s_addr] = s_wd;
      bus.csrReadData = s_re ? bus_mem[s_addr] : $urandom;
   end

   // Reference model: CSR semantics applied to ref_mem in access order
   task automatic predict(input bit port, input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] d, input int start, output int ack_cyc);
      logic [31:0] old, nv;
      logic        wn, ill;
      ack_exp_t    e;
      wr_exp_t     w;
      old = ref_mem[a];
      wn  = (op == 2'd1) || ((op != 2'd0) && (d != 32'd0));
      ill = wn && (a >= 12'hC00);
      case (op)
         2'd1:    nv = d;
         2'd2:    nv = old | d;
         2'd3:    nv = old & ~d;
         default: nv = old;
      endcase
      rd_q.push_back(a);
      if (wn && !ill) begin
         ref_mem[a] = nv;
         w.addr = a;
         w.data = nv;
         wr_q.push_back(w);
         ack_cyc = start + 4;
      end else begin
         ack_cyc = start + 3;
      end
      e.rdata = old;
      e.err   = ill;
      e.cyc   = ack_cyc;
      if (port) ack_q_dbg.push_back(e);
      else      ack_q_core.push_back(e);
   endtask

   task automatic drive_port(input bit port, input logic req, input logic [1:0] op,
                             input logic [11:0] a, input logic [31:0] d);
      if (!port) begin
         bus.coreRequest = req; bus.coreOp = op; bus.coreAddress = a; bus.coreWriteData = d;
      end else begin
         bus.debugRequest = req; bus.debugOp = op; bus.debugAddress = a; bus.debugWriteData = d;
      end
   endtask

   task automatic drop_port(input bit port);
      drive_port(port, 1'b0, 2'($urandom), 12'($urandom), $urandom);
   endtask

   function automatic logic port_ack(input bit port);
      return port ? bus.debugAck : bus.coreAck;
   endfunction

   task automatic single(input bit port, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] d, input bit wiggle);
      int t, ack_cyc;
      bit done;
      done = 1'b0;
      @(negedge clk);
      t = cyc;
      check("busy_before_grant", 32'(bus.busy), 32'd0);
      predict(port, op, a, d, t, ack_cyc);
      drive_port(port, 1'b1, op, a, d);
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         if (wiggle && i == 1) drive_port(port, 1'b1, op, 12'($urandom), $urandom);
         if (port_ack(port)) begin
            check("busy_in_resp", 32'(bus.busy), 32'd1);
            drop_port(port);
            done = 1'b1;
         end
      end
      if (!done) begin
         fail_now("single_ack_timeout");
         drop_port(port);
      end
   endtask

   task automatic tie_access(input logic [1:0] cop, input logic [11:0] ca, input logic [31:0] cd,
                             input logic [1:0] dop, input logic [11:0] da, input logic [31:0] dd);
      int t, aw, al;
      bit win, core_done, dbg_done;
      @(negedge clk);
      t = cyc;
      check("busy_before_tie", 32'(bus.busy), 32'd0);
      win     = ~tb_last;
      tb_last = win;
      if (!win) begin
         predict(1'b0, cop, ca, cd, t, aw);
         predict(1'b1, dop, da, dd, aw + 1, al);
      end else begin
         predict(1'b1, dop, da, dd, t, aw);
         predict(1'b0, cop, ca, cd, aw + 1, al);
      end
      drive_port(1'b0, 1'b1, cop, ca, cd);
      drive_port(1'b1, 1'b1, dop, da, dd);
      core_done = 1'b0;
      dbg_done  = 1'b0;
      for (int i = 0; i < 25 && !(core_done && dbg_done); i++) begin
         @(negedge clk);
         if (bus.coreAck && !core_done)  begin drop_port(1'b0); core_done = 1'b1; end
         if (bus.debugAck && !dbg_done)  begin drop_port(1'b1); dbg_done  = 1'b1; end
      end
      if (!(core_done && dbg_done)) begin
         fail_now("tie_ack_timeout");
         drop_port(1'b0);
         drop_port(1'b1);
      end
   endtask

   task automatic reset_mid_write();
      int t, ack_cyc;
      logic [31:0] saved;
      logic [11:0] a;
      bit hit;
      a   = 12'h345;
      hit = 1'b0;
      @(negedge clk);
      t     = cyc;
      saved = ref_mem[a];
      predict(1'b0, 2'd1, a, 32'hCAFEF00D, t, ack_cyc);
      drive_port(1'b0, 1'b1, 2'd1, a, 32'hCAFEF00D);
      for (int i = 0; i < 8 && !hit; i++) begin
         @(negedge clk);
         if (bus.csrWriteEnable) hit = 1'b1;
      end
      check("write_seen_before_reset", 32'(hit), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_write_enable_drop", 32'(bus.csrWriteEnable), 32'd0);
      check("rst_busy_drop", 32'(bus.busy), 32'd0);
      check("rst_core_ack", 32'(bus.coreAck), 32'd0);
      // the aborted access never reaches the CSR, so its effects are withdrawn
      ref_mem[a] = saved;
      ack_q_core.delete();
      tb_last = 1'b1;
      drop_port(1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      single(1'b0, 2'd0, a, 32'd0, 1'b0);
   endtask

   // Monitor: pops expectations whenever the DUT presents an ack or a bus strobe
   always @(negedge clk) begin
      ack_exp_t e;
      wr_exp_t  w;
      logic [11:0] ra;
      if (bus.coreAck) begin
         if (ack_q_core.size() == 0) fail_now("core_ack_unexpected");
         else begin
            e = ack_q_core.pop_front();
            check("core_read_data", bus.coreReadData, e.rdata);
            check("core_error", 32'(bus.coreError), 32'(e.err));
            check("core_ack_cycle", cyc, e.cyc);
         end
      end else begin
         check("core_idle_read_data", bus.coreReadData, 32'd0);
         check("core_idle_error", 32'(bus.coreError), 32'd0);
      end
      if (bus.debugAck) begin
         if (ack_q_dbg.size() == 0) fail_now("debug_ack_unexpected");
         else begin
            e = ack_q_dbg.pop_front();
            check("debug_read_data", bus.debugReadData, e.rdata);
            check("debug_error", 32'(bus.debugError), 32'(e.err));
            check("debug_ack_cycle", cyc, e.cyc);
         end
      end else begin
         check("debug_idle_read_data", bus.debugReadData, 32'd0);
         check("debug_idle_error", 32'(bus.debugError), 32'd0);
      end
      if (bus.csrReadEnable) begin
         check("no_read_write_overlap", 32'(bus.csrWriteEnable), 32'd0);
         if (rd_q.size() == 0) fail_now("read_strobe_unexpected");
         else begin
            ra = rd_q.pop_front();
            check("read_address", 32'(bus.csrAddress), 32'(ra));
         end
      end
      if (bus.csrWriteEnable) begin
         if (wr_q.size() == 0) fail_now("write_strobe_unexpected");
         else begin
            w = wr_q.pop_front();
            check("write_address", 32'(bus.csrAddress), 32'(w.addr));
            check("write_data", bus.csrWriteData, w.data);
         end
      end
      if (!bus.csrReadEnable && !bus.csrWriteEnable) begin
         check("idle_bus_address", 32'(bus.csrAddress), 32'd0);
         check("idle_bus_write_data", bus.csrWriteData, 32'd0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [11:0] ra, rb;
      logic [31:0] da, db;
      int kind;
      rst = 1'b1;
      drive_port(1'b0, 1'b0, 2'd0, 12'd0, 32'd0);
      drive_port(1'b1, 1'b0, 2'd0, 12'd0, 32'd0);
      for (int i = 0; i < 4096; i++) begin
         v = $urandom;
         bus_mem[i] = v;
         ref_mem[i] = v;
      end
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_read_enable", 32'(bus.csrReadEnable), 32'd0);
      check("reset_write_enable", 32'(bus.csrWriteEnable), 32'd0);
      check("reset_bus_address", 32'(bus.csrAddress), 32'd0);
      check("reset_bus_write_data", bus.csrWriteData, 32'd0);
      check("reset_core_ack", 32'(bus.coreAck), 32'd0);
      check("reset_debug_ack", 32'(bus.debugAck), 32'd0);
      rst = 1'b0;

      bus_mem[12'h340] = 32'h12345678; ref_mem[12'h340] = 32'h12345678;
      single(1'b0, 2'd1, 12'h340, 32'hDEADBEEF, 1'b0);
      bus_mem[12'h300] = 32'h3; ref_mem[12'h300] = 32'h3;
      single(1'b1, 2'd2, 12'h300, 32'h8, 1'b0);
      single(1'b1, 2'd3, 12'h300, 32'h1, 1'b0);
      single(1'b0, 2'd2, 12'hC00, 32'h0, 1'b0);
      single(1'b0, 2'd1, 12'hC00, 32'h55, 1'b0);
      tie_access(2'd0, 12'h010, 32'h0, 2'd0, 12'h020, 32'h0);
      tie_access(2'd1, 12'h030, 32'hA5A5A5A5, 2'd2, 12'h030, 32'h00F0000F);
      single(1'b0, 2'd1, 12'h123, 32'h600DF00D, 1'b1);
      reset_mid_write();
      tie_access(2'd3, 12'h040, 32'hFFFF0000, 2'd1, 12'h040, 32'h13572468);

      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 3);
         ra = ($urandom_range(0, 1) == 1) ? {2'($urandom), 10'($urandom_range(0, 7))} : 12'($urandom);
         rb = ($urandom_range(0, 1) == 1) ? ra : 12'($urandom);
         da = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         db = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         case (kind)
            0: single(1'b0, 2'($urandom), ra, da, 1'b0);
            1: single(1'b1, 2'($urandom), ra, da, 1'b0);
            2: tie_access(2'($urandom), ra, da, 2'($urandom), rb, db);
            default: single(1'b1, 2'($urandom), ra, da, 1'b1);
         endcase
      end

      repeat (4) @(negedge clk);
      check("drain_core_acks", ack_q_core.size(), 32'd0);
      check("drain_debug_acks", ack_q_dbg.size(), 32'd0);
      check("drain_reads", rd_q.size(), 32'd0);
      check("drain_writes", wr_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
